// File: rtl/secuenciador_medicion_pkg.sv
// rtl/secuenciador_medicion_pkg.sv - shared constants for the measurement sequencer
package secuenciador_medicion_pkg;

  // Display mode encodings
  localparam logic [1:0] MODO_VEL     = 2'd0;
  localparam logic [1:0] MODO_ACEL    = 2'd1;
  localparam logic [1:0] MODO_VUELTAS = 2'd2;

  // Four-digit display limit
  localparam int unsigned MAX_DISPLAY_DEF = 9999;

  // Sequencer FSM states
  localparam logic [1:0] ST_CONTAR   = 2'd0;
  localparam logic [1:0] ST_MULT     = 2'd1;
  localparam logic [1:0] ST_DELTA    = 2'd2;
  localparam logic [1:0] ST_PUBLICAR = 2'd3;

  // Clamp a wide unsigned value to the display limit
  function automatic logic [15:0] saturar(input logic [23:0] x, input logic [15:0] lim);
    return (x > {8'd0, lim}) ? lim : x[15:0];
  endfunction

endpackage

// File: rtl/secuenciador_medicion_multiplicador_serie.sv
// rtl/secuenciador_medicion_multiplicador_serie.sv - 8x16 serial shift-add multiplier
module multiplicador_serie (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [15:0] b_i,
  output logic [23:0] p_o,
  output logic        done_o
);

  logic [7:0]  a_q;
  logic [23:0] b_q;
  logic [23:0] p_q;
  logic [3:0]  cnt_q;

  // start loads operands; each following cycle retires one multiplier bit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= {8'd0, b_i};
      p_q   <= '0;
      cnt_q <= 4'd8;
    end else if (cnt_q != 4'd0) begin
      if (a_q[0]) begin
        p_q <= p_q + b_q;
      end
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign p_o = p_q;
  // High during the cycle whose closing edge retires the eighth bit, so the
  // parent leaves its multiply state on the same edge the product settles.
  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/secuenciador_medicion.sv
// rtl/secuenciador_medicion.sv - gate-window speed/accel/revolution sequencer
module secuenciador_medicion
  import secuenciador_medicion_pkg::*;
#(
  parameter int unsigned VENTANA_CICLOS = 50_000_000,
  parameter int unsigned MAX_PULSOS     = 255,
  parameter int unsigned MAX_DISPLAY    = MAX_DISPLAY_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        imanImpulso,
  input  logic        botonModo,
  input  logic [15:0] circunferencia,
  output logic [15:0] valor_display,
  output logic [1:0]  modo,
  output logic        acel_negativa,
  output logic        muestra_valida,
  output logic        sobrecarga
);

  localparam int GW = $clog2(VENTANA_CICLOS);
  localparam logic [GW-1:0] GATE_FIN    = GW'(VENTANA_CICLOS - 1);
  localparam logic [7:0]    PULSOS_TOPE = 8'(MAX_PULSOS);
  localparam logic [15:0]   LIM         = 16'(MAX_DISPLAY);

  logic [GW-1:0] gate_q, gate_d;
  logic          fin_ventana;
  logic [7:0]    pulsos_q, pulsos_d;
  logic          sat_q, sat_d;
  logic [1:0]    estado_q, estado_d;
  logic [7:0]    pulsos_snap_q;
  logic          sat_snap_q;
  logic          mult_start;
  logic [23:0]   producto;
  logic          mult_done;

  logic [15:0]        v_nuevo;
  logic signed [16:0] dif;
  logic [16:0]        dif_abs;
  logic [15:0]        acel_nuevo;
  logic               desborde;
  logic [23:0]        vueltas_suma;

  logic [15:0] vnew_q, acel_calc_q;
  logic        neg_calc_q, ovf_calc_q;
  logic [15:0] vel_pub_q, acel_pub_q, vueltas_q, v_prev_q;
  logic        neg_q, sobre_q, strobe_q;
  logic [1:0]  modo_q, modo_d;
  logic [15:0] valor_q, valor_d;

  assign fin_ventana = (gate_q == GATE_FIN);
  assign mult_start  = (estado_q == ST_CONTAR) && fin_ventana;

  // Free-running gate counter and per-window impulse counter
  always_comb begin
    gate_d   = fin_ventana ? '0 : gate_q + 1'b1;
    pulsos_d = pulsos_q;
    sat_d    = sat_q;
    if (fin_ventana) begin
      // an impulse landing on the window edge belongs to the new window
      pulsos_d = imanImpulso ? 8'd1 : 8'd0;
      sat_d    = 1'b0;
    end else if (imanImpulso) begin
      if (pulsos_q == PULSOS_TOPE) begin
        sat_d = 1'b1;
      end else begin
        pulsos_d = pulsos_q + 8'd1;
      end
    end
  end

  // Counter registers plus the end-of-window snapshot
  always_ff @(posedge clock) begin
    if (!resetn) begin
      gate_q        <= '0;
      pulsos_q      <= '0;
      sat_q         <= 1'b0;
      pulsos_snap_q <= '0;
      sat_snap_q    <= 1'b0;
    end else begin
      gate_q   <= gate_d;
      pulsos_q <= pulsos_d;
      sat_q    <= sat_d;
      if (mult_start) begin
        pulsos_snap_q <= pulsos_q;
        sat_snap_q    <= sat_q;
      end
    end
  end

  multiplicador_serie u_mult (
    .clock   (clock),
    .resetn  (resetn),
    .start_i (mult_start),
    .a_i     (pulsos_q),
    .b_i     (circunferencia),
    .p_o     (producto),
    .done_o  (mult_done)
  );

  // Sequencer next state: count, multiply, difference, publish
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_CONTAR:   if (fin_ventana) estado_d = ST_MULT;
      ST_MULT:     if (mult_done)   estado_d = ST_DELTA;
      ST_DELTA:    estado_d = ST_PUBLICAR;
      ST_PUBLICAR: estado_d = ST_CONTAR;
      default:     estado_d = ST_CONTAR;
    endcase
  end

  // Speed clamp, signed speed difference and overflow summary
  always_comb begin
    v_nuevo      = saturar(producto, LIM);
    dif          = $signed({1'b0, v_nuevo}) - $signed({1'b0, v_prev_q});
    dif_abs      = dif[16] ? (17'd0 - $unsigned(dif)) : $unsigned(dif);
    acel_nuevo   = saturar({7'd0, dif_abs}, LIM);
    desborde     = sat_snap_q | (producto > {8'd0, LIM}) | (dif_abs > {1'b0, LIM});
    vueltas_suma = {8'd0, vueltas_q} + {16'd0, pulsos_snap_q};
  end

  // FSM state, delta-stage results and published snapshot
  always_ff @(posedge clock) begin
    if (!resetn) begin
      estado_q    <= ST_CONTAR;
      vnew_q      <= '0;
      acel_calc_q <= '0;
      neg_calc_q  <= 1'b0;
      ovf_calc_q  <= 1'b0;
      vel_pub_q   <= '0;
      acel_pub_q  <= '0;
      vueltas_q   <= '0;
      v_prev_q    <= '0;
      neg_q       <= 1'b0;
      sobre_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      strobe_q <= (estado_q == ST_PUBLICAR);
      if (estado_q == ST_DELTA) begin
        vnew_q      <= v_nuevo;
        acel_calc_q <= acel_nuevo;
        neg_calc_q  <= dif[16];
        ovf_calc_q  <= desborde;
      end
      if (estado_q == ST_PUBLICAR) begin
        vel_pub_q  <= vnew_q;
        acel_pub_q <= acel_calc_q;
        neg_q      <= neg_calc_q;
        sobre_q    <= ovf_calc_q;
        v_prev_q   <= vnew_q;
        vueltas_q  <= saturar(vueltas_suma, LIM);
      end
    end
  end

  // Mode advance and display mux; mux reads registered mode and values
  always_comb begin
    case (modo_q)
      MODO_VEL:     modo_d = MODO_ACEL;
      MODO_ACEL:    modo_d = MODO_VUELTAS;
      default:      modo_d = MODO_VEL;
    endcase
    if (!botonModo) begin
      modo_d = modo_q;
    end
    case (modo_q)
      MODO_VEL:     valor_d = vel_pub_q;
      MODO_ACEL:    valor_d = acel_pub_q;
      MODO_VUELTAS: valor_d = vueltas_q;
      default:      valor_d = '0;
    endcase
  end

  // Mode and display registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      modo_q  <= MODO_VEL;
      valor_q <= '0;
    end else begin
      modo_q  <= modo_d;
      valor_q <= valor_d;
    end
  end

  assign valor_display  = valor_q;
  assign modo           = modo_q;
  assign acel_negativa  = neg_q;
  assign muestra_valida = strobe_q;
  assign sobrecarga     = sobre_q;

endmodule

// File: tb/tb_secuenciador_medicion.sv
// tb/tb_secuenciador_medicion.sv - directed bench for the measurement sequencer
module tb_secuenciador_medicion;

  logic        clock = 1'b0;
  logic        resetn, iman, boton;
  logic [15:0] circ;
  logic [15:0] valor;
  logic [1:0]  modo;
  logic        neg, strobe, sobre;

  logic        resetn_s, iman_s, boton_s;
  logic [15:0] circ_s;
  logic [15:0] valor_s;
  logic [1:0]  modo_s;
  logic        neg_s, strobe_s, sobre_s;

  int n_vec = 0;
  int n_bad = 0;
  int edge_n = 0;
  int edge_s = 0;
  int at;

  always #5 clock = ~clock;

  secuenciador_medicion #(.VENTANA_CICLOS(100)) u_dut (
    .clock(clock), .resetn(resetn), .imanImpulso(iman), .botonModo(boton),
    .circunferencia(circ), .valor_display(valor), .modo(modo),
    .acel_negativa(neg), .muestra_valida(strobe), .sobrecarga(sobre)
  );

  // longer window so 300 impulses fit into one gate
  secuenciador_medicion #(.VENTANA_CICLOS(320)) u_dut_sat (
    .clock(clock), .resetn(resetn_s), .imanImpulso(iman_s), .botonModo(boton_s),
    .circunferencia(circ_s), .valor_display(valor_s), .modo(modo_s),
    .acel_negativa(neg_s), .muestra_valida(strobe_s), .sobrecarga(sobre_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
    edge_s++;
  endtask

  task automatic ir_a(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic pulso(input int e);
    ir_a(e - 1);
    iman = 1'b1;
    tick();
    iman = 1'b0;
  endtask

  task automatic pulsar(input int e);
    ir_a(e - 1);
    boton = 1'b1;
    tick();
    boton = 1'b0;
  endtask

  task automatic wait_strobe(input bit sat, input int lim, output int at_e);
    at_e = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (sat ? strobe_s : strobe) begin
        at_e = sat ? edge_s : edge_n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; iman = 1'b0; boton = 1'b0; circ = 16'd210;
    resetn_s = 1'b0; iman_s = 1'b0; boton_s = 1'b0; circ_s = 16'd210;
    repeat (3) tick();
    n_vec++; if (valor !== 16'd0) begin n_bad++; $display("FAIL reset_valor got %0d want 0", valor); end
    n_vec++; if (modo !== 2'd0) begin n_bad++; $display("FAIL reset_modo got %0d want 0", modo); end
    n_vec++; if ({neg, strobe, sobre} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {neg, strobe, sobre}); end
    resetn = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_idle_windows();
    wait_strobe(1'b0, 200, at);
    n_vec++; if (at !== 110) begin n_bad++; $display("FAIL idle_strobe1 edge %0d want 110", at); end
    tick();
    n_vec++; if (strobe !== 1'b0) begin n_bad++; $display("FAIL idle_strobe_width got %b want 0", strobe); end
    n_vec++; if (valor !== 16'd0) begin n_bad++; $display("FAIL idle_speed got %0d want 0", valor); end
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 210) begin n_bad++; $display("FAIL idle_strobe2 edge %0d want 210", at); end
    n_vec++; if ({neg, sobre} !== 2'b00) begin n_bad++; $display("FAIL idle_flags got %b want 00", {neg, sobre}); end
  endtask

  task automatic test_speed();
    pulso(211); pulso(213); pulso(215);
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 310) begin n_bad++; $display("FAIL speed_strobe edge %0d want 310", at); end
    n_vec++; if ({neg, sobre} !== 2'b00) begin n_bad++; $display("FAIL speed_flags got %b want 00", {neg, sobre}); end
    tick();
    n_vec++; if (valor !== 16'd630) begin n_bad++; $display("FAIL speed_630 got %0d want 630", valor); end
    pulsar(312); tick();
    n_vec++; if (valor !== 16'd630) begin n_bad++; $display("FAIL speed_accel got %0d want 630", valor); end
    pulsar(314); tick();
    n_vec++; if (valor !== 16'd3) begin n_bad++; $display("FAIL speed_revs got %0d want 3", valor); end
    pulsar(316); tick();
    n_vec++; if (modo !== 2'd0 || valor !== 16'd630) begin n_bad++; $display("FAIL speed_wrap modo %0d valor %0d want 0/630", modo, valor); end
  endtask

  task automatic test_decel();
    pulso(330);
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 410) begin n_bad++; $display("FAIL decel_strobe edge %0d want 410", at); end
    n_vec++; if (neg !== 1'b1) begin n_bad++; $display("FAIL decel_neg got %b want 1", neg); end
    tick();
    n_vec++; if (valor !== 16'd210) begin n_bad++; $display("FAIL decel_speed got %0d want 210", valor); end
  endtask

  task automatic test_mode();
    pulsar(420); tick();
    n_vec++; if (modo !== 2'd1 || valor !== 16'd420) begin n_bad++; $display("FAIL mode_accel modo %0d valor %0d want 1/420", modo, valor); end
    pulsar(425); tick();
    n_vec++; if (modo !== 2'd2 || valor !== 16'd4) begin n_bad++; $display("FAIL mode_revs modo %0d valor %0d want 2/4", modo, valor); end
    pulsar(430); tick();
    n_vec++; if (modo !== 2'd0 || valor !== 16'd210) begin n_bad++; $display("FAIL mode_speed modo %0d valor %0d want 0/210", modo, valor); end
    pulso(440); pulso(441); pulso(442); pulso(443);
    ir_a(509);
    boton = 1'b1;
    tick();
    boton = 1'b0;
    n_vec++; if (strobe !== 1'b1 || modo !== 2'd1) begin n_bad++; $display("FAIL mode_coinc strobe %b modo %0d want 1/1", strobe, modo); end
    tick();
    n_vec++; if (valor !== 16'd630) begin n_bad++; $display("FAIL mode_coinc_val got %0d want 630", valor); end
    pulsar(520); tick();
    n_vec++; if (valor !== 16'd8) begin n_bad++; $display("FAIL mode_revs8 got %0d want 8", valor); end
    pulsar(525); tick();
    n_vec++; if (valor !== 16'd840) begin n_bad++; $display("FAIL mode_speed840 got %0d want 840", valor); end
  endtask

  task automatic test_window_edge();
    pulso(600);
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 610) begin n_bad++; $display("FAIL wedge_strobe edge %0d want 610", at); end
    n_vec++; if (neg !== 1'b1) begin n_bad++; $display("FAIL wedge_neg got %b want 1", neg); end
    tick();
    n_vec++; if (valor !== 16'd0) begin n_bad++; $display("FAIL wedge_old got %0d want 0", valor); end
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 710) begin n_bad++; $display("FAIL wedge_strobe2 edge %0d want 710", at); end
    tick();
    n_vec++; if (valor !== 16'd210 || neg !== 1'b0) begin n_bad++; $display("FAIL wedge_new valor %0d neg %b want 210/0", valor, neg); end
  endtask

  task automatic test_reset_mid();
    pulso(720); pulso(721);
    ir_a(802);
    resetn = 1'b0;
    tick();
    n_vec++; if (valor !== 16'd0 || modo !== 2'd0) begin n_bad++; $display("FAIL rmid_outs valor %0d modo %0d want 0/0", valor, modo); end
    n_vec++; if ({neg, strobe, sobre} !== 3'b000) begin n_bad++; $display("FAIL rmid_flags got %b want 000", {neg, strobe, sobre}); end
    resetn = 1'b1;
    edge_n = 0;
    pulso(50);
    wait_strobe(1'b0, 150, at);
    n_vec++; if (at !== 110) begin n_bad++; $display("FAIL rmid_strobe edge %0d want 110", at); end
    tick();
    n_vec++; if (valor !== 16'd210) begin n_bad++; $display("FAIL rmid_speed got %0d want 210", valor); end
    pulsar(120); tick();
    n_vec++; if (valor !== 16'd210) begin n_bad++; $display("FAIL rmid_accel got %0d want 210", valor); end
    pulsar(122); tick();
    n_vec++; if (valor !== 16'd1) begin n_bad++; $display("FAIL rmid_revs got %0d want 1", valor); end
  endtask

  task automatic test_saturation();
    resetn_s = 1'b1;
    edge_s = 0;
    iman_s = 1'b1;
    while (edge_s < 300) tick();
    iman_s = 1'b0;
    wait_strobe(1'b1, 100, at);
    n_vec++; if (at !== 330) begin n_bad++; $display("FAIL sat_strobe edge %0d want 330", at); end
    n_vec++; if (sobre_s !== 1'b1 || neg_s !== 1'b0) begin n_bad++; $display("FAIL sat_flags sobre %b neg %b want 1/0", sobre_s, neg_s); end
    tick();
    n_vec++; if (valor_s !== 16'd9999) begin n_bad++; $display("FAIL sat_speed got %0d want 9999", valor_s); end
    wait_strobe(1'b1, 400, at);
    n_vec++; if (at !== 650) begin n_bad++; $display("FAIL sat_strobe2 edge %0d want 650", at); end
    n_vec++; if (sobre_s !== 1'b0 || neg_s !== 1'b1) begin n_bad++; $display("FAIL sat_clear sobre %b neg %b want 0/1", sobre_s, neg_s); end
    tick();
    n_vec++; if (valor_s !== 16'd0) begin n_bad++; $display("FAIL sat_speed0 got %0d want 0", valor_s); end
  endtask

  initial begin
    test_reset();
    test_idle_windows();
    test_speed();
    test_decel();
    test_mode();
    test_window_edge();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
